hash_sender: RTL and testbench

HASH_SENDER -- requirements
Module: hash_sender

---
 rtl/hash_pkg.sv | 21 ++
 rtl/uart_tx_byte.sv | 103 ++++++++++
 rtl/hash_sender.sv | 102 ++++++++++
 tb/tb_hash_sender.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
// ----------------------------------------------------------------------------
// hash_pkg: shared sender state encoding and default parameters. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } sender_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_DIGEST_BYTES = 32;

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ----------------------------------------------------------------------------
// uart_tx_byte: 8N1 serializer for one byte, can chain frames back-to-back. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_byte
  import hash_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_in_i,
  output logic       tx_o,
  output logic       done_o
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  sender_state_t     state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              w_baud_last;

  assign w_baud_last = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            shift_q <= data_in_i;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (w_baud_last) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (w_baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q   <= '0;
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (w_baud_last) begin
            baud_q <= '0;
            // Chaining straight into the next start bit avoids an idle gap.
            if (start_i) begin
              shift_q <= data_in_i;
              bit_q   <= '0;
              tx_q    <= 1'b0;
              state_q <= ST_START;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_o   = tx_q;
  assign done_o = (state_q == ST_STOP) && w_baud_last;

endmodule

`default_nettype wire

// File: rtl/hash_sender.sv
// ----------------------------------------------------------------------------
// hash_sender: captures a digest and streams it MSB byte first over UART. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hash_sender
  import hash_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DIGEST_BYTES = DEFAULT_DIGEST_BYTES
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      write_enable,
  input  logic [8*DIGEST_BYTES-1:0] digest,
  output logic                      tx,
  output logic                      finished_sending,
  output logic                      busy
);

  localparam int               IDX_W    = (DIGEST_BYTES > 1) ? $clog2(DIGEST_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGEST_BYTES - 1);

  // ST_START spans the whole digest here; bit-level phases live in uart_tx_byte.
  sender_state_t             state_q;
  logic [8*DIGEST_BYTES-1:0] shift_q;
  logic [IDX_W-1:0]          byte_idx_q;
  logic                      finished_q;
  logic                      busy_q;

  logic                      w_capture;
  logic                      w_byte_done;
  logic                      w_byte_start;
  logic [7:0]                w_byte_data;

  assign w_capture    = (state_q == ST_IDLE) && write_enable;
  assign w_byte_start = w_capture ||
                        ((state_q == ST_START) && w_byte_done && (byte_idx_q != IDX_LAST));
  assign w_byte_data  = w_capture ? digest[8*DIGEST_BYTES-1 -: 8]
                                  : shift_q[8*DIGEST_BYTES-1 -: 8];

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      byte_idx_q <= '0;
      finished_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      finished_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (write_enable) begin
            shift_q    <= digest << 8;
            byte_idx_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (w_byte_done) begin
            if (byte_idx_q == IDX_LAST) begin
              finished_q <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              byte_idx_q <= byte_idx_q + IDX_W'(1);
              shift_q    <= shift_q << 8;
            end
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          if (!write_enable) begin
            byte_idx_q <= '0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk      (clk),
    .rst_i    (rst_i),
    .start_i  (w_byte_start),
    .data_in_i(w_byte_data),
    .tx_o     (tx),
    .done_o   (w_byte_done)
  );

  assign finished_sending = finished_q;
  assign busy             = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_hash_sender.sv
// ----------------------------------------------------------------------------
// tb_hash_sender: directed vector bench for hash_sender at 4 clocks per bit. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hash_sender;

  localparam int CPB     = 4;
  localparam int NB      = 32;
  localparam int FRAME   = 10 * CPB;
  localparam int FIN_AT  = NB * FRAME;
  localparam int NS      = FIN_AT + 60;

  logic            clk;
  logic            rst_i;
  logic            write_enable;
  logic [8*NB-1:0] digest;
  logic            tx;
  logic            finished_sending;
  logic            busy;

  hash_sender #(
    .CLKS_PER_BIT(CPB),
    .DIGEST_BYTES(NB)
  ) dut (
    .clk             (clk),
    .rst_i           (rst_i),
    .write_enable    (write_enable),
    .digest          (digest),
    .tx              (tx),
    .finished_sending(finished_sending),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] digest;
    int           drop_at;
    int           hold_after_fin;
    int           dig_chg;
    logic [7:0]   b0;
    logic [7:0]   b5;
    logic [7:0]   b31;
    bit           chk_seq;
  } vec_t;

  vec_t vecs[4];
  int   total = 0;
  int   bad   = 0;
  logic tx_s   [NS];
  logic fin_s  [NS];
  logic busy_s [NS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; the capture happens on the next rising edge.
  task automatic run_and_check(input vec_t v, input string tag);
    int         fin_cnt = 0;
    int         fin_idx = -1;
    int         tail_low = 0;
    int         tail_busy = 0;
    logic [7:0] got [NB];
    logic [9:0] seq55 = 10'b1010101010;
    digest       = v.digest;
    write_enable = 1'b1;
    @(posedge clk);
    for (int n = 0; n < NS; n++) begin
      @(negedge clk);
      tx_s[n]   = tx;
      fin_s[n]  = finished_sending;
      busy_s[n] = busy;
      if (finished_sending) begin
        fin_cnt++;
        if (fin_idx < 0) fin_idx = n;
      end
      if (n == v.dig_chg) digest = '1;
      if (n == v.drop_at) write_enable = 1'b0;
      if (fin_idx >= 0 && v.hold_after_fin >= 0 && n == fin_idx + v.hold_after_fin)
        write_enable = 1'b0;
    end
    write_enable = 1'b0;

    for (int k = 0; k < NB; k++) begin
      logic [7:0] b  = '0;
      logic       ok = 1'b1;
      int         base = k * FRAME;
      for (int i = 0; i < 10; i++) begin
        for (int j = 0; j < CPB; j++) begin
          logic s = tx_s[base + i*CPB + j];
          if (s !== tx_s[base + i*CPB]) ok = 1'b0;
          if (i == 0 && s !== 1'b0) ok = 1'b0;
          if (i == 9 && s !== 1'b1) ok = 1'b0;
        end
        if (i >= 1 && i <= 8) b[i-1] = tx_s[base + i*CPB];
      end
      got[k] = b;
      check($sformatf("%s frame%0d", tag, k), {55'd0, ok, b}, {55'd0, 1'b1, v.digest[255-8*k -: 8]});
    end

    check({tag, " byte0"},  got[0],  v.b0);
    check({tag, " byte5"},  got[5],  v.b5);
    check({tag, " byte31"}, got[31], v.b31);
    check({tag, " fin_count"}, fin_cnt, 1);
    check({tag, " fin_cycle"}, fin_idx, FIN_AT);
    check({tag, " busy_first"}, busy_s[0], 1'b1);
    check({tag, " busy_at_fin"}, busy_s[FIN_AT], 1'b1);
    for (int n = FIN_AT; n < NS; n++) if (tx_s[n] !== 1'b1) tail_low++;
    for (int n = FIN_AT + 1; n < NS; n++) if (busy_s[n] !== 1'b0) tail_busy++;
    check({tag, " tail_tx_low"}, tail_low, 0);
    check({tag, " tail_busy"}, tail_busy, 0);

    if (v.chk_seq) begin
      for (int i = 0; i < 10; i++)
        for (int j = 0; j < CPB; j++)
          check($sformatf("%s seq bit%0d.%0d", tag, i, j), tx_s[i*CPB + j], seq55[i]);
    end

    repeat (3) @(negedge clk);
    check({tag, " idle_tx"}, tx, 1'b1);
    check({tag, " idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    int fin_seen = 0;

    vecs[0] = '{256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20,
                -1, 0, -1, 8'h01, 8'h06, 8'h20, 1'b0};
    vecs[1] = '{{32{8'h55}}, -1, 50, -1, 8'h55, 8'h55, 8'h55, 1'b1};
    vecs[2] = '{{8{32'hDEADBEEF}}, -1, 0, 10, 8'hDE, 8'hAD, 8'hEF, 1'b0};
    vecs[3] = '{{16{16'hFF00}}, 100, -1, -1, 8'hFF, 8'h00, 8'h00, 1'b0};

    rst_i        = 1'b1;
    write_enable = 1'b0;
    digest       = '0;
    repeat (2) @(negedge clk);
    check("reset tx", tx, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset fin", finished_sending, 1'b0);
    rst_i = 1'b0;
    @(negedge clk);
    check("post_reset tx", tx, 1'b1);

    for (int t = 0; t < 4; t++) run_and_check(vecs[t], $sformatf("vec%0d", t));

    // Reset mid-frame: byte 5 (0x06) data bit 3 occupies cycles 216..219.
    digest       = vecs[0].digest;
    write_enable = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 217; n++) begin
      @(negedge clk);
      if (finished_sending) fin_seen++;
    end
    check("midreset tx_before", tx, 1'b0);
    rst_i = 1'b1;
    #1;
    check("midreset tx_async", tx, 1'b1);
    check("midreset busy_async", busy, 1'b0);
    write_enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (finished_sending) fin_seen++;
      if (tx !== 1'b1) fin_seen += 100;
    end
    check("midreset no_fin_quiet_line", fin_seen, 0);
    run_and_check(vecs[0], "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
